// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift_arbiter slice: width helpers, slot
// state encoding and the flattened-request slice index helpers.
// Optional feature macro used elsewhere in this slice: SHIFT_ARB_OVF_EN.
package shift_arbiter_pkg;

   localparam int DEFAULT_WIDTH   = 8;
   localparam int DEFAULT_NUM_REQ = 4;

   // The output stage is either empty or holding one result.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_t;

   // Ceiling log2; counts how many bits are needed to index 'value' items.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int w = value - 1; w > 0; w = w >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Width of one shift-amount field for a given operand width.
   function automatic int shift_width(input int width);
      return clog2(width);
   endfunction

   // Width of the requester index for a given requester count.
   function automatic int id_width(input int num_req);
      return clog2(num_req);
   endfunction

   // Lowest bit of requester idx inside the flattened operand bus.
   function automatic int bits_lo(input int idx, input int width);
      return idx * width;
   endfunction

   // Lowest bit of requester idx inside the flattened shift-amount bus.
   function automatic int shift_lo(input int idx, input int shift_w);
      return idx * shift_w;
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle for shift_arbiter. The slave modport is the arbiter
// side; the master modport is the producers-plus-consumer side.
// With SHIFT_ARB_OVF_EN defined the bundle also carries out_ovf.
interface shift_arbiter_if
   import shift_arbiter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int NUM_REQ = DEFAULT_NUM_REQ
);

   localparam int SHIFT_W = shift_width(WIDTH);
   localparam int ID_W    = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*WIDTH-1:0]   req_bits;
   logic [NUM_REQ*SHIFT_W-1:0] req_shift;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       out_valid;
   logic [WIDTH-1:0]           out_bits;
   logic [ID_W-1:0]            out_id;
   logic                       out_ready;
`ifdef SHIFT_ARB_OVF_EN
   logic                       out_ovf;
`endif

   modport slave (
      input  req_valid,
      input  req_bits,
      input  req_shift,
      output req_ready,
      output out_valid,
      output out_bits,
      output out_id,
`ifdef SHIFT_ARB_OVF_EN
      output out_ovf,
`endif
      input  out_ready
   );

   modport master (
      output req_valid,
      output req_bits,
      output req_shift,
      input  req_ready,
      input  out_valid,
      input  out_bits,
      input  out_id,
`ifdef SHIFT_ARB_OVF_EN
      input  out_ovf,
`endif
      output out_ready
   );

endinterface

// File: rtl/shift_arbiter_shifter.sv
// Generic combinational left shifter. Bits shifted past the top are lost;
// shift amounts of 'width' or more give zero.
// With SHIFT_ARB_OVF_EN defined it also reports whether any 1 bit was lost.
module shift_arbiter_shifter
   import shift_arbiter_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH
) (
   input  logic [width-1:0]              data,
   input  logic [shift_width(width)-1:0] shift,
`ifdef SHIFT_ARB_OVF_EN
   output logic                          ovf,
`endif
   output logic [width-1:0]              result
);

`ifdef SHIFT_ARB_OVF_EN
   localparam int SW   = shift_width(width);
   localparam int SPAN = width + (1 << SW);

   logic [SPAN-1:0] wide;

   // Shift into a field wide enough to keep every lost bit for the flag.
   always_comb begin
      wide = {{(SPAN-width){1'b0}}, data} << shift;
   end

   assign result = wide[width-1:0];
   assign ovf    = |wide[SPAN-1:width];
`else
   assign result = data << shift;
`endif

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one left shifter among NUM_REQ requesters,
// with a single-entry output register that honours backpressure.
// Optional: define SHIFT_ARB_OVF_EN to add the registered out_ovf flag.
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
   input logic         clk,
   input logic         rst,
   shift_arbiter_if.slave bus
);

   localparam int SHIFT_W = shift_width(WIDTH);
   localparam int ID_W    = id_width(NUM_REQ);

   slot_state_t state, state_next;

   logic [WIDTH-1:0]   op_bits  [NUM_REQ];
   logic [SHIFT_W-1:0] op_shift [NUM_REQ];

   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_next;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    scan_idx;
   int                 scan_sum;
   logic               grant_hit;
   logic               grant;
   logic               slot_free;
   logic [NUM_REQ-1:0] ready_vec;

   logic [WIDTH-1:0]   sel_bits;
   logic [SHIFT_W-1:0] sel_shift;
   logic [WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]   out_bits_q;
   logic [ID_W-1:0]    out_id_q;

`ifdef SHIFT_ARB_OVF_EN
   logic               shift_ovf;
   logic               out_ovf_q;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign op_bits[gi]  = bus.req_bits[bits_lo(gi, WIDTH) +: WIDTH];
         assign op_shift[gi] = bus.req_shift[shift_lo(gi, SHIFT_W) +: SHIFT_W];
      end
   endgenerate

   assign slot_free = (state == ST_EMPTY) || bus.out_ready;

   // Find the first valid requester at or above ptr, wrapping to zero.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      scan_sum  = 0;
      scan_idx  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         scan_sum = int'(ptr) + off;
         if (scan_sum >= NUM_REQ) begin
            scan_sum = scan_sum - NUM_REQ;
         end
         scan_idx = ID_W'(scan_sum);
         if (!grant_hit && bus.req_valid[scan_idx]) begin
            grant_hit = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   assign grant = !rst && slot_free && grant_hit;

   // Raise the accept strobe for the winner only.
   always_comb begin
      ready_vec = '0;
      if (grant) begin
         ready_vec[grant_idx] = 1'b1;
      end
   end

   assign bus.req_ready = ready_vec;

   assign sel_bits  = op_bits[grant_idx];
   assign sel_shift = op_shift[grant_idx];
   assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

`ifdef SHIFT_ARB_OVF_EN
   shift_arbiter_shifter #(.width(WIDTH)) u_shifter (
      .data   (sel_bits),
      .shift  (sel_shift),
      .ovf    (shift_ovf),
      .result (shifted)
   );
`else
   shift_arbiter_shifter #(.width(WIDTH)) u_shifter (
      .data   (sel_bits),
      .shift  (sel_shift),
      .result (shifted)
   );
`endif

   // Slot occupancy register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // A grant always fills the slot (replacing a draining result); a drain
   // without a grant empties it; otherwise the slot keeps its state.
   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: begin
            if (grant) begin
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (grant) begin
               state_next = ST_FULL;
            end else if (bus.out_ready) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // Capture the winner's result and advance the pointer only on a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_bits_q <= '0;
         out_id_q   <= '0;
         ptr        <= '0;
`ifdef SHIFT_ARB_OVF_EN
         out_ovf_q  <= 1'b0;
`endif
      end else if (grant) begin
         out_bits_q <= shifted;
         out_id_q   <= grant_idx;
         ptr        <= ptr_next;
`ifdef SHIFT_ARB_OVF_EN
         out_ovf_q  <= shift_ovf;
`endif
      end
   end

   assign bus.out_valid = (state == ST_FULL);
   assign bus.out_bits  = out_bits_q;
   assign bus.out_id    = out_id_q;
`ifdef SHIFT_ARB_OVF_EN
   assign bus.out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (WIDTH=8, NUM_REQ=4): a directed
// vector table, a fairness sequence and a randomized run against a model.
// Checks out_ovf as well when SHIFT_ARB_OVF_EN is defined.
module tb_shift_arbiter;
   import shift_arbiter_pkg::*;

   localparam int WIDTH   = 8;
   localparam int NUM_REQ = 4;
   localparam int SHIFT_W = 3;
   localparam int NVEC    = 18;

   localparam logic [31:0] BITS_A  = 32'h81_05_0F_01;
   localparam logic [11:0] SHIFT_A = 12'h298;
   localparam logic [11:0] SHIFT_B = 12'h29F;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   shift_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

   shift_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int check_count = 0;
   int pass_count  = 0;

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] bits;
      logic [11:0] shift;
      logic        oready;
      logic [3:0]  exp_ready;
      logic        exp_valid;
      logic [7:0]  exp_bits;
      logic [1:0]  exp_id;
      logic        exp_ovf;
   } vec_t;

   vec_t vectors [NVEC];

   // Reference model state: the held result and the round-robin pointer.
   int   m_ptr;
   logic m_valid;
   int   m_bits;
   int   m_id;
   logic m_ovf;

   task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] b,
                      input logic [11:0] s, input logic o);
      rst           = r;
      bus.req_valid = v;
      bus.req_bits  = b;
      bus.req_shift = s;
      bus.out_ready = o;
      #3;
   endtask

   function automatic int modelGrant(input logic r, input logic [3:0] v, input logic o);
      if (r) return -1;
      if (m_valid && !o) return -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task modelCommit(input logic r, input logic [31:0] b, input logic [11:0] s,
                    input logic o, input int g);
      int op;
      int sh;
      int prod;
      if (r) begin
         m_ptr = 0; m_valid = 1'b0; m_bits = 0; m_id = 0; m_ovf = 1'b0;
      end else if (g >= 0) begin
         op      = int'((b >> (g * WIDTH)) & 32'hFF);
         sh      = int'((s >> (g * SHIFT_W)) & 12'h7);
         prod    = op * (1 << sh);
         m_bits  = prod % 256;
         m_ovf   = (prod >= 256);
         m_id    = g;
         m_ptr   = (g + 1) % NUM_REQ;
         m_valid = 1'b1;
      end else if (o) begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      int g;
      logic r, o;
      logic [3:0] v;
      logic [31:0] b;
      logic [11:0] s;
      logic [3:0] er;

      vectors[0]  = '{1'b1, 4'hF, BITS_A, SHIFT_A, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
      vectors[1]  = '{1'b1, 4'hF, BITS_A, SHIFT_A, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
      vectors[2]  = '{1'b0, 4'h2, BITS_A, SHIFT_A, 1'b1, 4'h2, 1'b1, 8'h78, 2'd1, 1'b0};
      vectors[3]  = '{1'b0, 4'h0, BITS_A, SHIFT_A, 1'b1, 4'h0, 1'b0, 8'h78, 2'd1, 1'b0};
      vectors[4]  = '{1'b0, 4'hF, BITS_A, SHIFT_A, 1'b1, 4'h4, 1'b1, 8'h14, 2'd2, 1'b0};
      vectors[5]  = '{1'b0, 4'hF, BITS_A, SHIFT_A, 1'b1, 4'h8, 1'b1, 8'h02, 2'd3, 1'b1};
      vectors[6]  = '{1'b0, 4'hF, BITS_A, SHIFT_A, 1'b1, 4'h1, 1'b1, 8'h01, 2'd0, 1'b0};
      vectors[7]  = '{1'b0, 4'hF, BITS_A, SHIFT_A, 1'b1, 4'h2, 1'b1, 8'h78, 2'd1, 1'b0};
      vectors[8]  = '{1'b0, 4'hF, BITS_A, SHIFT_A, 1'b0, 4'h0, 1'b1, 8'h78, 2'd1, 1'b0};
      vectors[9]  = '{1'b0, 4'hF, BITS_A, SHIFT_A, 1'b0, 4'h0, 1'b1, 8'h78, 2'd1, 1'b0};
      vectors[10] = '{1'b0, 4'hF, BITS_A, SHIFT_A, 1'b0, 4'h0, 1'b1, 8'h78, 2'd1, 1'b0};
      vectors[11] = '{1'b0, 4'h4, BITS_A, SHIFT_A, 1'b1, 4'h4, 1'b1, 8'h14, 2'd2, 1'b0};
      vectors[12] = '{1'b0, 4'h0, BITS_A, SHIFT_A, 1'b0, 4'h0, 1'b1, 8'h14, 2'd2, 1'b0};
      vectors[13] = '{1'b0, 4'h0, BITS_A, SHIFT_A, 1'b1, 4'h0, 1'b0, 8'h14, 2'd2, 1'b0};
      vectors[14] = '{1'b0, 4'h2, BITS_A, SHIFT_A, 1'b1, 4'h2, 1'b1, 8'h78, 2'd1, 1'b0};
      vectors[15] = '{1'b1, 4'hF, BITS_A, SHIFT_A, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
      vectors[16] = '{1'b0, 4'hC, BITS_A, SHIFT_A, 1'b1, 4'h4, 1'b1, 8'h14, 2'd2, 1'b0};
      vectors[17] = '{1'b0, 4'h1, BITS_A, SHIFT_B, 1'b1, 4'h1, 1'b1, 8'h80, 2'd0, 1'b0};

      #1;
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vectors[i].rst, vectors[i].valid, vectors[i].bits,
                       vectors[i].shift, vectors[i].oready);
         checkOutput($sformatf("vec%0d req_ready", i), 32'(bus.req_ready), 32'(vectors[i].exp_ready));
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vectors[i].exp_valid));
         checkOutput($sformatf("vec%0d out_bits", i), 32'(bus.out_bits), 32'(vectors[i].exp_bits));
         checkOutput($sformatf("vec%0d out_id", i), 32'(bus.out_id), 32'(vectors[i].exp_id));
`ifdef SHIFT_ARB_OVF_EN
         checkOutput($sformatf("vec%0d out_ovf", i), 32'(bus.out_ovf), 32'(vectors[i].exp_ovf));
`endif
      end

      // Fairness: after reset, continuous requests from all four give 0,1,2,3,0,...
      applyStimulus(1'b1, 4'hF, BITS_A, SHIFT_A, 1'b1);
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 4'hF, BITS_A, SHIFT_A, 1'b1);
         checkOutput($sformatf("rr%0d req_ready", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
         @(posedge clk);
         #1;
         checkOutput($sformatf("rr%0d out_valid", k), 32'(bus.out_valid), 32'd1);
         checkOutput($sformatf("rr%0d out_id", k), 32'(bus.out_id), 32'(k % 4));
      end

      // Randomized run against the reference model, starting from reset.
      m_ptr = 0; m_valid = 1'b0; m_bits = 0; m_id = 0; m_ovf = 1'b0;
      applyStimulus(1'b1, 4'h0, 32'h0, 12'h0, 1'b0);
      @(posedge clk);
      #1;
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 39) == 0);
         v = 4'($urandom);
         b = $urandom;
         s = 12'($urandom);
         o = ($urandom_range(0, 3) != 0);
         g = modelGrant(r, v, o);
         er = (g >= 0) ? 4'(1 << g) : 4'h0;
         applyStimulus(r, v, b, s, o);
         checkOutput($sformatf("rand%0d req_ready", n), 32'(bus.req_ready), 32'(er));
         @(posedge clk);
         #1;
         modelCommit(r, b, s, o, g);
         checkOutput($sformatf("rand%0d out_valid", n), 32'(bus.out_valid), 32'(m_valid));
         checkOutput($sformatf("rand%0d out_bits", n), 32'(bus.out_bits), 32'(m_bits));
         checkOutput($sformatf("rand%0d out_id", n), 32'(bus.out_id), 32'(m_id));
`ifdef SHIFT_ARB_OVF_EN
         checkOutput($sformatf("rand%0d out_ovf", n), 32'(bus.out_ovf), 32'(m_ovf));
`endif
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
